rf_scoreboard: RTL
==================

RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 SHALL have parameter RFW, default 5, meaning register index width (2**RFW registers).
REQ-002 SHALL have parameter DW, default 32, meaning register data width.
REQ-003 SHALL have port clk  input  1  meaning sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset; synchronous, active-high.
REQ-005 SHALL have port issue_valid  input  1  meaning decode presents an instruction.
REQ-006 SHALL have ports issue_rs1, issue_rs2  input  RFW  meaning source register indices.
REQ-007 SHALL have port issue_rd  input  RFW  meaning destination index.
REQ-008 SHALL have port issue_wen  input  1  meaning the instruction writes issue_rd.
REQ-009 SHALL have port issue_ready  output  1  meaning no hazard, issue may proceed.
REQ-010 SHALL have ports alu_wb_valid/mem_wb_valid  input  1, alu_wb_reg/mem_wb_reg  input  RFW, alu_wb_data/mem_wb_data  input  DW  meaning writeback requests.
REQ-011 SHALL have ports alu_wb_ready, mem_wb_ready  output  1  meaning the request is granted this cycle.
REQ-012 SHALL have ports rf_we  output  1, rf_wreg  output  RFW, rf_wdata  output  DW  meaning registered single write port to the register file.
REQ-013 SHALL have port stall_cnt  output  16  meaning hazard-stall cycle count.

Function
REQ-014 SHALL hold busy[2**RFW-1:0], one pending-write bit per register; busy[0] is constant 0.
REQ-015 SHALL drive issue_ready combinationally = !busy[rs1] & !busy[rs2] & !(issue_wen & busy[rd]); register index 0 never causes a hazard.
REQ-016 SHALL, on an edge with issue_valid & issue_ready & issue_wen & rd!=0, set busy[rd].
REQ-017 SHALL arbitrate the single write port with a 2-state FSM PRI_MEM/PRI_ALU: one valid requester is granted; both valid -> the side named by the state wins.
REQ-018 SHALL move the FSM on each contested grant to favour the loser (MEM granted -> PRI_ALU; ALU granted -> PRI_MEM); uncontested grants leave the state unchanged.
REQ-019 SHALL drive *_wb_ready combinationally in the request cycle; requesters hold valid/reg/data until granted.
REQ-020 SHALL register a grant to rf_we=1, rf_wreg, rf_wdata for exactly the next cycle (1-cycle latency); no grant -> rf_we=0 next cycle.
REQ-021 SHALL suppress rf_we for a granted writeback to register 0 (grant still given, busy unchanged).
REQ-022 SHALL clear busy[rf_wreg] on the edge at which rf_we=1; issue_ready for that register rises the cycle after rf_we.
REQ-023 SHALL let set win when REQ-016 set and REQ-022 clear target the same register on the same edge.
REQ-024 SHALL write a granted writeback to a non-busy register normally without altering busy.

Reset
REQ-025 SHALL, on an edge with rst=1, clear all busy bits, set FSM to PRI_MEM, drive rf_we=0, rf_wreg=0, rf_wdata=0, stall_cnt=0; in-flight grants are discarded.
REQ-026 SHALL ignore issue and writeback inputs on edges with rst=1; issue_ready is 1 the cycle after reset.

Configuration
REQ-027 SHALL honour macro RF_SCOREBOARD_STALL_CNT_EN: defined -> stall_cnt increments on each edge with issue_valid & !issue_ready, saturating at 16'hFFFF; undefined -> stall_cnt constant 0 and no counter logic.

Verification
REQ-028 SHALL cover: issue rd=5 wen=1; next cycle issue rs1=5 -> issue_ready=0 until the cycle after rf_we=1 with rf_wreg=5.
REQ-029 SHALL cover: alu and mem both valid, regs 3 and 4, three consecutive cycles after reset -> grants MEM, ALU, MEM; rf_wreg sequence 4,3,4 each one cycle later.
REQ-030 SHALL cover: writeback reg 0 data 32'hDEADBEEF -> *_wb_ready=1, rf_we stays 0; issue rs1=0 rs2=0 -> issue_ready=1.
REQ-031 SHALL cover: issue rd=7 on same edge that rf_we=1 clears reg 7 -> busy[7]=1 afterwards, issue rs1=7 stalls.
REQ-032 SHALL cover: rst=1 with busy[9]=1 and grant pending -> next cycle rf_we=0, issue rs1=9 issue_ready=1, stall_cnt=0.
REQ-033 SHALL cover (macro defined): 10 stall cycles -> stall_cnt=10; preset near 16'hFFFF -> holds 16'hFFFF.

Source files
------------

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write tracking with an alternating-priority single writeback port.
// Optional hazard-stall counter is built only when RF_SCOREBOARD_STALL_CNT_EN is defined.
module rf_scoreboard #(
    parameter int RFW = 5,
    parameter int DW  = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           issue_valid,
    input  logic [RFW-1:0] issue_rs1,
    input  logic [RFW-1:0] issue_rs2,
    input  logic [RFW-1:0] issue_rd,
    input  logic           issue_wen,
    output logic           issue_ready,
    input  logic           alu_wb_valid,
    input  logic [RFW-1:0] alu_wb_reg,
    input  logic [DW-1:0]  alu_wb_data,
    output logic           alu_wb_ready,
    input  logic           mem_wb_valid,
    input  logic [RFW-1:0] mem_wb_reg,
    input  logic [DW-1:0]  mem_wb_data,
    output logic           mem_wb_ready,
    output logic           rf_we,
    output logic [RFW-1:0] rf_wreg,
    output logic [DW-1:0]  rf_wdata,
    output logic [15:0]    stall_cnt
);
    // state   | meaning
    // PRI_MEM | mem side wins a contested writeback
    // PRI_ALU | alu side wins a contested writeback
    typedef enum logic {PRI_MEM = 1'b0, PRI_ALU = 1'b1} pri_t;

    localparam int NREG = 2**RFW;
    localparam logic [NREG-1:0] KEEP_MASK = {{(NREG-1){1'b1}}, 1'b0};

    pri_t            state;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic            alu_grant;
    logic            mem_grant;
    logic            issue_fire;

    assign issue_ready = !busy[issue_rs1] && !busy[issue_rs2] && !(issue_wen && busy[issue_rd]);
    assign issue_fire  = issue_valid && issue_ready && issue_wen && (issue_rd != '0);

    // No grant is handed out while in reset: the write would be discarded anyway.
    assign mem_grant    = !rst && mem_wb_valid && (!alu_wb_valid || state == PRI_MEM);
    assign alu_grant    = !rst && alu_wb_valid && (!mem_wb_valid || state == PRI_ALU);
    assign mem_wb_ready = mem_grant;
    assign alu_wb_ready = alu_grant;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_fire) set_mask[issue_rd] = 1'b1;
        if (rf_we)      clr_mask[rf_wreg]  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= PRI_MEM;
            busy     <= '0;
            rf_we    <= 1'b0;
            rf_wreg  <= '0;
            rf_wdata <= '0;
        end else begin
            // Set is applied after clear so a same-edge reissue keeps the register busy.
            busy  <= ((busy & ~clr_mask) | set_mask) & KEEP_MASK;
            rf_we <= 1'b0;
            if (mem_grant) begin
                rf_we    <= (mem_wb_reg != '0);
                rf_wreg  <= mem_wb_reg;
                rf_wdata <= mem_wb_data;
            end else if (alu_grant) begin
                rf_we    <= (alu_wb_reg != '0);
                rf_wreg  <= alu_wb_reg;
                rf_wdata <= alu_wb_data;
            end
            if (mem_grant && alu_wb_valid) begin
                state <= PRI_ALU;
            end else if (alu_grant && mem_wb_valid) begin
                state <= PRI_MEM;
            end
        end
    end

`ifdef RF_SCOREBOARD_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (issue_valid && !issue_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule
